// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        filled;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// Module : fetch_queue
// Brief  : Circular buffer of in-flight/returned fetches, filled in order.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int         CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          alloc,
   input  logic [31:0]   alloc_pc,
   input  logic          fill,
   input  logic [31:0]   fill_data,
   input  logic          pop,
   input  logic          flush,
   output logic          head_valid,
   output logic [31:0]   head_pc,
   output logic [31:0]   head_instr,
   output logic [CW-1:0] occupancy,
   output logic [CW-1:0] unfilled
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  entries_q [DEPTH];
   fetch_entry_t  entries_d [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW-1:0] fillp_q, fillp_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] unf_q, unf_d;

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      fillp_d   = fillp_q;
      count_d   = count_q;
      unf_d     = unf_q;

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].filled = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         fillp_d = '0;
         count_d = '0;
         unf_d   = '0;
      end else begin
         // Pop frees the head before a same-cycle alloc may reuse that slot.
         if (pop) begin
            entries_d[head_q].filled = 1'b0;
            head_d = head_q + AW'(1);
         end
         if (alloc) begin
            entries_d[tail_q].pc     = alloc_pc;
            entries_d[tail_q].instr  = NOP_INSTR;
            entries_d[tail_q].filled = 1'b0;
            tail_d = tail_q + AW'(1);
         end
         if (fill) begin
            entries_d[fillp_q].instr  = fill_data;
            entries_d[fillp_q].filled = 1'b1;
            fillp_d = fillp_q + AW'(1);
         end
         count_d = count_q + CW'(alloc) - CW'(pop);
         unf_d   = unf_q + CW'(alloc) - CW'(fill);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR, filled: 1'b0};
         end
         head_q  <= '0;
         tail_q  <= '0;
         fillp_q <= '0;
         count_q <= '0;
         unf_q   <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         fillp_q   <= fillp_d;
         count_q   <= count_d;
         unf_q     <= unf_d;
      end
   end

   always_comb begin
      head_valid = (count_q != '0) && entries_q[head_q].filled;
      head_pc    = entries_q[head_q].pc;
      head_instr = head_valid ? entries_q[head_q].instr : NOP_INSTR;
      occupancy  = count_q;
      unfilled   = unf_q;
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// Module : fetch_unit
// Brief  : RV32I fetch stage: PC, imem request issue, redirect flush, decode handoff.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int            CW        = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_LIM = DEPTH[CW:0];

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] discard_q, discard_d;

   logic          head_valid;
   logic [31:0]   head_pc;
   logic [31:0]   head_instr;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] unfilled;
   logic          pop;
   logic          alloc;
   logic          fill;
   logic          rsp_drop;
   logic [CW:0]   budget;
   logic [CW-1:0] owed;

   always_comb begin
      id_valid = head_valid && !redirect_valid;
      pop      = id_valid && id_ready;

      // Stale responses still owed count against the request budget.
      budget         = {1'b0, occupancy} + {1'b0, discard_q};
      imem_req_valid = !redirect_valid && ((budget < DEPTH_LIM) || pop);
      alloc          = imem_req_valid && imem_req_ready;

      rsp_drop = imem_rsp_valid && !redirect_valid && (discard_q != '0);
      fill     = imem_rsp_valid && !redirect_valid && (discard_q == '0) && (unfilled != '0);

      owed = discard_q + unfilled;

      pc_d      = pc_q;
      discard_d = discard_q;
      if (redirect_valid) begin
         pc_d      = redirect_pc & 32'hFFFF_FFFC;
         discard_d = owed - CW'(imem_rsp_valid && (owed != '0));
      end else begin
         if (alloc) begin
            pc_d = pc_q + PC_STEP;
         end
         if (rsp_drop) begin
            discard_d = discard_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   always_comb begin
      imem_req_addr = pc_q;
      id_instr      = head_instr;
      id_pc         = head_pc;
   end

   fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc      (alloc),
      .alloc_pc   (pc_q),
      .fill       (fill),
      .fill_data  (imem_rsp_data),
      .pop        (pop),
      .flush      (redirect_valid),
      .head_valid (head_valid),
      .head_pc    (head_pc),
      .head_instr (head_instr),
      .occupancy  (occupancy),
      .unfilled   (unfilled)
   );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// Module : tb_fetch_unit
// Brief  : Randomized and directed bench for fetch_unit against a queue-based model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int lat_lo = 1;
   int lat_hi = 1;
   int last_due = 0;

   // Model: program-order list of fetches still owned by the stage.
   typedef struct {
      logic [31:0] pc;
      bit          filled;
   } ment_t;
   ment_t fq[$];
   int    disc;
   logic [31:0] exp_pc;

   // Memory: in-order pending responses.
   typedef struct {
      int          due;
      logic [31:0] data;
   } mrsp_t;
   mrsp_t mq[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h9E37_79B9;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compare process + model/memory update, once per cycle.
   always @(negedge clk) begin : p_compare
      bit    e_idv, e_pop, e_rqv, acc;
      int    n_unf, due;
      ment_t t;
      if (!rst_n) begin
         chk("rst_id_valid", 32'(id_valid), 32'd0);
         chk("rst_id_instr", id_instr, NOP);
         chk("rst_id_pc", id_pc, RESET_PC);
         chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
         chk("rst_req_addr", imem_req_addr, RESET_PC);
         fq.delete();
         mq.delete();
         disc     = 0;
         exp_pc   = RESET_PC;
         last_due = 0;
      end else begin
         e_idv = (fq.size() > 0) && fq[0].filled && !redirect_valid;
         e_pop = e_idv && id_ready;
         e_rqv = !redirect_valid && (((fq.size() + disc) < DEPTH) || e_pop);
         chk("req_valid", 32'(imem_req_valid), 32'(e_rqv));
         if (e_rqv) chk("req_addr", imem_req_addr, exp_pc);
         chk("id_valid", 32'(id_valid), 32'(e_idv));
         if (e_idv) begin
            chk("id_pc", id_pc, fq[0].pc);
            chk("id_instr", id_instr, mem_word(fq[0].pc));
         end
         acc = e_rqv && imem_req_ready;

         if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
         if (imem_req_valid && imem_req_ready) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            mq.push_back('{due: due, data: mem_word(imem_req_addr)});
            last_due = due;
         end

         n_unf = 0;
         foreach (fq[i]) if (!fq[i].filled) n_unf++;

         if (redirect_valid) begin
            disc = disc + n_unf - (imem_rsp_valid ? 1 : 0);
            if (disc < 0) disc = 0;
            fq.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (imem_rsp_valid) begin
               if (disc > 0) begin
                  disc--;
               end else begin
                  chk("rsp_has_owner", 32'(n_unf > 0), 32'd1);
                  for (int i = 0; i < fq.size(); i++) begin
                     if (!fq[i].filled) begin
                        t = fq[i];
                        t.filled = 1'b1;
                        fq[i] = t;
                        break;
                     end
                  end
               end
            end
            if (e_pop) void'(fq.pop_front());
            if (acc) begin
               fq.push_back('{pc: exp_pc, filled: 1'b0});
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
      cyc++;
   end

   task automatic step(input bit rdy, input bit idr, input bit rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      imem_req_ready = rdy;
      id_ready       = idr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq[0].data;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
   endtask

   task automatic drive_idle();
      imem_req_ready = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_seq(input string name, input logic [31:0] got[$],
                            input logic [31:0] start, input int n);
      if (got.size() < n) begin
         chk({name, "_count"}, 32'(got.size()), 32'(n));
      end else begin
         for (int i = 0; i < n; i++) chk(name, got[i], start + 32'(4 * i));
      end
   endtask

   initial begin : p_stim
      logic [31:0] got[$];
      int first, nv, acc;
      bit rdy, idr, rv;
      logic [31:0] rpc;

      rst_n = 1'b0;
      drive_idle();
      repeat (3) @(posedge clk);

      // Streaming with a 1-cycle memory: one instruction per cycle.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      first = -1; nv = 0;
      for (int c = 0; c < 30; c++) begin
         step(1, 1, 0, '0);
         if (id_valid) begin
            if (first < 0) first = c;
            got.push_back(id_pc);
            if (c >= 2) nv++;
         end
      end
      chk("p1_first_id_cycle", 32'(first), 32'd2);
      chk("p1_no_bubble", 32'(nv), 32'd28);
      check_seq("p1_pc_order", got, 32'h0, 8);

      // Decode stalled: only DEPTH requests go out, head frozen.
      do_reset();
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         step(1, 0, 0, '0);
         if (imem_req_valid && imem_req_ready) acc++;
      end
      chk("p2_accepts", 32'(acc), 32'(DEPTH));
      chk("p2_id_valid", 32'(id_valid), 32'd1);
      chk("p2_id_pc", id_pc, 32'h0);
      chk("p2_id_instr", id_instr, mem_word(32'h0));
      got.delete();
      for (int c = 0; c < 8; c++) begin
         step(1, 1, 0, '0);
         if (id_valid) got.push_back(id_pc);
      end
      check_seq("p2_drain", got, 32'h0, 4);

      // Redirect with three requests outstanding on a 5-cycle memory.
      do_reset();
      lat_lo = 5; lat_hi = 5;
      for (int c = 0; c < 3; c++) step(1, 1, 0, '0);
      step(1, 1, 1, 32'h100);
      chk("p3_redir_req_valid", 32'(imem_req_valid), 32'd0);
      chk("p3_redir_id_valid", 32'(id_valid), 32'd0);
      step(1, 1, 0, '0);
      chk("p3_next_req_valid", 32'(imem_req_valid), 32'd1);
      chk("p3_next_req_addr", imem_req_addr, 32'h100);
      got.delete();
      for (int c = 0; c < 20; c++) begin
         step(1, 1, 0, '0);
         if (id_valid) got.push_back(id_pc);
      end
      check_seq("p3_after_redir", got, 32'h100, 3);

      // Redirect colliding with a response and a pop; misaligned target.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      for (int c = 0; c < 6; c++) step(1, 1, 0, '0);
      step(1, 1, 1, 32'h103);
      chk("p4_redir_id_valid", 32'(id_valid), 32'd0);
      step(1, 1, 0, '0);
      chk("p4_next_req_valid", 32'(imem_req_valid), 32'd1);
      chk("p4_next_req_addr", imem_req_addr, 32'h100);
      got.delete();
      for (int c = 0; c < 10; c++) begin
         step(1, 1, 0, '0);
         if (id_valid) got.push_back(id_pc);
      end
      check_seq("p4_after_redir", got, 32'h100, 3);

      // PC wrap at the top of the address space.
      step(1, 1, 1, 32'hFFFF_FFF8);
      got.delete();
      for (int c = 0; c < 12; c++) begin
         step(1, 1, 0, '0);
         if (id_valid) got.push_back(id_pc);
      end
      check_seq("p5_wrap", got, 32'hFFFF_FFF8, 4);

      // Asynchronous reset with a full queue.
      for (int c = 0; c < 8; c++) step(1, 0, 0, '0);
      chk("p6_full_id_valid", 32'(id_valid), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive_idle();
      #2;
      chk("p6_async_id_valid", 32'(id_valid), 32'd0);
      chk("p6_async_req_addr", imem_req_addr, RESET_PC);
      chk("p6_async_id_instr", id_instr, NOP);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      got.delete();
      for (int c = 0; c < 10; c++) begin
         step(1, 1, 0, '0);
         if (c == 0) chk("p6_post_id_valid", 32'(id_valid), 32'd0);
         if (id_valid) got.push_back(id_pc);
      end
      check_seq("p6_restart", got, RESET_PC, 3);

      // Random traffic against the model.
      lat_lo = 1; lat_hi = 4;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) do_reset();
         rdy = ($urandom_range(0, 3) != 0);
         idr = ($urandom_range(0, 2) != 0);
         rv  = ($urandom_range(0, 29) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom);
         step(rdy, idr, rv, rpc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined RV32I core. Holds the program counter, issues in-order word requests to instruction memory, buffers returned instruction words with their PCs, and hands them one at a time to the decode stage, which feeds the immediate generator and control decoder. Branch/jump redirects from execute flush all buffered and in-flight fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, fetch queue entries (power of two, ≥2); also the cap on outstanding requests

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  response valid; in order, ≥1 cycle after acceptance, no backpressure
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  taken branch/jump from execute
- redirect_pc  input  32  new fetch target
- id_valid  output  1  instruction available to decode
- id_ready  input  1  decode consumes instruction
- id_instr  output  32  instruction word (InstrCode to decode)
- id_pc  output  32  PC of id_instr

## Operation
- Circular queue of DEPTH entries {pc, instr, filled}. Entry allocated at request acceptance with pc and filled=0; next unfilled entry (oldest first) written and marked filled on an accepted response.
- discard_cnt: responses still owed for requests issued before a redirect; width clog2(DEPTH+1).
- Issue: imem_req_valid = !redirect_valid && (occupancy + discard_cnt < DEPTH || pop this cycle). imem_req_addr = pc_q. On valid&&ready: allocate, pc_q += 4 (wraps modulo 2^32).
- Response: if discard_cnt > 0, drop and decrement; else fill oldest unfilled entry.
- Head: id_valid = head allocated && filled && !redirect_valid; id_instr/id_pc from head. Pop on id_valid && id_ready.
- Redirect (highest priority): pc_q <= {redirect_pc[31:2], 2'b00}; every queue entry freed; discard_cnt <= discard_cnt + unfilled_entries − (imem_rsp_valid ? 1 : 0); no request, no pop, no fill that cycle.
- Simultaneous pop and allocate: allowed, occupancy unchanged.
- Response with no unfilled entry and discard_cnt = 0: protocol error, dropped; assertion in bench.

## Timing
- Reset values: pc_q = RESET_PC, queue empty, discard_cnt = 0; imem_req_valid = 1 from the first cycle after rst_n rises (addr RESET_PC); id_valid = 0, id_instr = 32'h0000_0013 (NOP), id_pc = RESET_PC.
- Reset asserted mid-operation: all state cleared immediately; responses for pre-reset requests are the memory's responsibility to suppress.
- Latency: request accepted cycle N, response cycle N+k, id_valid earliest N+k+1.
- Throughput: 1 instruction/cycle sustained with 1-cycle memory and id_ready held high.
- Redirect in cycle R: first request at redirect target in R+1; id_valid low in R and until the new target's response is filled.
- id_valid/id_instr/id_pc stable while id_valid && !id_ready, except a redirect deasserts id_valid.

## Structure
- fetch_pkg: fetch_entry_t struct {pc, instr, filled}; NOP_INSTR = 32'h0000_0013; PC_STEP = 4.
- Sub-module fetch_queue: DEPTH-entry circular buffer with alloc/fill/pop/flush ports, occupancy and unfilled counts; fetch_unit holds pc_q, discard_cnt and the handshake logic.

## Test plan
- Reset release, 1-cycle memory, id_ready=1 -> requests at 0x0,0x4,0x8…, one per cycle; id_pc/id_instr match from cycle 3 onward, no bubbles.
- id_ready=0 for 10 cycles -> exactly DEPTH=4 requests accepted, id outputs frozen on PC 0x0; on release drains 0x0,0x4,0x8,0xC in order.
- 3 outstanding (memory latency 5), redirect_pc=0x100 -> discard_cnt=3, three stale responses dropped, first id_pc after redirect = 0x100.
- Redirect in same cycle as a response and a pop -> response counted as discarded, no pop, next request 0x100 in following cycle.
- redirect_pc=0x103 -> next imem_req_addr = 0x100; pc_q at 0xFFFF_FFFC wraps to 0x0.
- rst_n asserted with full queue -> id_valid=0, imem_req_addr=RESET_PC immediately, queue empty after release.
